rr_to_bpm: RTL

RR_TO_BPM -- requirements
Module: rr_to_bpm

---
 rtl/rr_to_bpm.sv | 119 +++++++++++
 1 files changed

// File: rtl/rr_to_bpm.sv
// Converts a Q4.11 R-R interval to integer heart rate with a serial restoring divider,
// and keeps a 4-sample moving average of the results.
module rr_to_bpm #(
    parameter int unsigned SCALE   = 122880,
    parameter int unsigned BPM_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rr_interval,
    input  logic        rr_valid,
    output logic [7:0]  bpm,
    output logic        bpm_valid,
    output logic        bpm_sat,
    output logic [7:0]  avg_bpm,
    output logic        avg_valid,
    output logic        busy,
    output logic        err_invalid,
    output logic        overrun
);

    // state | meaning
    // IDLE  | waiting for rr_valid; rejects negative or zero intervals
    // DIV   | 17 shift-subtract steps, down-counter cnt runs 16..0
    // DONE  | publish bpm, update history/average, back to IDLE
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state;
    logic [14:0] mag;
    logic [16:0] quo;
    logic [15:0] rem;
    logic [4:0]  cnt;
    logic [7:0]  hist [4];
    logic [9:0]  sum;
    logic [1:0]  fill;

    logic [16:0] rem_shift;
    logic        rem_ge;
    logic [15:0] rem_diff;
    logic        q_sat;
    logic [7:0]  new_bpm;
    logic [9:0]  sum_next;

    always_comb begin
        rem_shift = {rem, quo[16]};
        rem_ge    = rem_shift >= {2'b00, mag};
        // remainder stays below mag, so 16 bits always hold the difference
        rem_diff  = rem_shift[15:0] - {1'b0, mag};
        q_sat     = quo > 17'(BPM_MAX);
        new_bpm   = q_sat ? 8'(BPM_MAX) : quo[7:0];
        sum_next  = sum + {2'b00, new_bpm} - {2'b00, hist[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag         <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            sum         <= '0;
            fill        <= '0;
            bpm         <= '0;
            bpm_valid   <= 1'b0;
            bpm_sat     <= 1'b0;
            avg_bpm     <= '0;
            avg_valid   <= 1'b0;
            busy        <= 1'b0;
            err_invalid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            bpm_valid   <= 1'b0;
            avg_valid   <= 1'b0;
            err_invalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_valid) begin
                        if (rr_interval[15] || rr_interval[14:0] == 15'd0) begin
                            err_invalid <= 1'b1;
                        end else begin
                            mag   <= rr_interval[14:0];
                            quo   <= 17'(SCALE);
                            rem   <= '0;
                            cnt   <= 5'd16;
                            busy  <= 1'b1;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (rr_valid) overrun <= 1'b1;
                    quo <= {quo[15:0], rem_ge};
                    rem <= rem_ge ? rem_diff : rem_shift[15:0];
                    if (cnt == 5'd0) state <= DONE;
                    else             cnt   <= cnt - 5'd1;
                end
                DONE: begin
                    if (rr_valid) overrun <= 1'b1;
                    bpm       <= new_bpm;
                    bpm_sat   <= q_sat;
                    bpm_valid <= 1'b1;
                    hist[0]   <= new_bpm;
                    hist[1]   <= hist[0];
                    hist[2]   <= hist[1];
                    hist[3]   <= hist[2];
                    sum       <= sum_next;
                    avg_bpm   <= sum_next[9:2];
                    // fill == 3 means at least three earlier results, so this one completes four
                    avg_valid <= (fill == 2'd3);
                    if (fill != 2'd3) fill <= fill + 2'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
